// File: rtl/accum_sequencer_if.sv
// Handshake/data bundle between an accum_sequencer and whatever drives it.
// The master drives the request side; the slave (the sequencer) drives status.
interface accum_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int LED_W = 8
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                   enable;
    logic                   mode;
    logic [NCH-1:0]         ch_mask;
    logic [NCH*WIDTH-1:0]   value;
    logic [WIDTH-1:0]       count;
    logic [LED_W-1:0]       led;
    logic [SEL_W-1:0]       ch_sel;
    logic                   busy;
    logic                   acc_pulse;
    logic                   ovf;

    modport master (
        output enable, mode, ch_mask, value,
        input  count, led, ch_sel, busy, acc_pulse, ovf
    );

    modport slave (
        input  enable, mode, ch_mask, value,
        output count, led, ch_sel, busy, acc_pulse, ovf
    );
endinterface

// File: rtl/accum_sequencer.sv
// Multi-channel delayed accumulator: IDLE -> WAIT(DELAY) -> ACC, round-robin over ch_mask.
// Define ACCUM_SAT_EN to make the add saturate and drive a sticky ovf; otherwise it wraps.
module accum_sequencer #(
    parameter int WIDTH   = 32,
    parameter int NCH     = 4,
    parameter int DELAY   = 2,
    parameter int LED_W   = 8,
    parameter int LED_LSB = 16
) (
    input  logic               CLK,
    input  logic               RST,
    accum_sequencer_if.slave   bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [DW-1:0]    DLY_LOAD = DW'(DELAY - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t             state;
    logic [DW-1:0]      dcnt;
    logic [WIDTH-1:0]   count_q;
    logic [SEL_W-1:0]   sel_q;
    logic               busy_q;
    logic               pulse_q;

    logic               found;
    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   pick_next;
    logic [WIDTH-1:0]   chan_val;

`ifdef ACCUM_SAT_EN
    // Result carries the overflow flag in its MSB.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : {1'b0, s[WIDTH-1:0]};
    endfunction

    logic [WIDTH:0] add_res;
    logic           ovf_q;
    assign add_res = sat_add(count_q, chan_val);
`else
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    logic [WIDTH-1:0] add_res;
    assign add_res = wrap_add(count_q, chan_val);
`endif

    // Round-robin search starting at the current pointer, first set mask bit wins.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(sel_q) + i) % NCH;
            if (!found && bus.ch_mask[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    assign pick_next = (pick == SEL_LAST) ? '0 : pick + 1'b1;
    assign chan_val  = bus.value[int'(pick)*WIDTH +: WIDTH];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            dcnt    <= '0;
            count_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
`ifdef ACCUM_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state  <= WAIT;
                        dcnt   <= DLY_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dcnt == '0) begin
                        state <= ACC;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                ACC: begin
                    if (found) begin
                        sel_q   <= pick_next;
                        pulse_q <= 1'b1;
`ifdef ACCUM_SAT_EN
                        count_q <= add_res[WIDTH-1:0];
                        if (add_res[WIDTH]) begin
                            ovf_q <= 1'b1;
                        end
`else
                        count_q <= add_res;
`endif
                    end
                    // Continuous mode re-arms straight into WAIT, skipping IDLE.
                    if (bus.mode && bus.enable) begin
                        state <= WAIT;
                        dcnt  <= DLY_LOAD;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.led       = count_q[LED_LSB +: LED_W];
    assign bus.ch_sel    = sel_q;
    assign bus.busy      = busy_q;
    assign bus.acc_pulse = pulse_q;
`ifdef ACCUM_SAT_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer (NCH=4, DELAY=2); expectations follow ACCUM_SAT_EN.
module tb_accum_sequencer;
    localparam int WIDTH   = 32;
    localparam int NCH     = 4;
    localparam int DELAY   = 2;
    localparam int LED_W   = 8;
    localparam int LED_LSB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    accum_sequencer_if #(.WIDTH(WIDTH), .NCH(NCH), .LED_W(LED_W)) bus ();

    accum_sequencer #(
        .WIDTH(WIDTH), .NCH(NCH), .DELAY(DELAY), .LED_W(LED_W), .LED_LSB(LED_LSB)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse enable for one cycle, then count busy cycles until the sequence ends.
    task automatic run_oneshot(output int busy_cycles, output logic pulse);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles <= 20) begin
            busy_cycles++;
            tick();
        end
        pulse = bus.acc_pulse;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.mode = 1'b0;
        bus.ch_mask = 4'b0000;
        bus.value = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        tick();
        checks++; if (bus.count !== 32'd0) begin failures++; $display("FAIL reset_count actual=%h required=%h", bus.count, 32'd0); end
        checks++; if (bus.led !== 8'd0) begin failures++; $display("FAIL reset_led actual=%h required=%h", bus.led, 8'd0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.ch_sel !== 2'd0) begin failures++; $display("FAIL reset_ch_sel actual=%0d required=0", bus.ch_sel); end
        checks++; if (bus.acc_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse actual=%b required=0", bus.acc_pulse); end
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf actual=%b required=0", bus.ovf); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_release_start actual=%b required=1", bus.busy); end
        bus.enable = 1'b0;
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_drain_idle actual=%b required=0", bus.busy); end
        checks++; if (bus.count !== 32'd0) begin failures++; $display("FAIL reset_drain_count actual=%h required=%h", bus.count, 32'd0); end
    endtask

    task automatic test_continuous();
        logic [31:0] exp_count [5] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd11};
        logic [1:0]  exp_sel   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int gap;
        do_reset();
        bus.value = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.ch_mask = 4'b1111;
        bus.mode = 1'b1;
        bus.enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (bus.acc_pulse !== 1'b1 && gap <= 20);
            checks++; if (gap != ((n == 0) ? 4 : 3)) begin failures++; $display("FAIL cont_period[%0d] actual=%0d required=%0d", n, gap, (n == 0) ? 4 : 3); end
            checks++; if (bus.count !== exp_count[n]) begin failures++; $display("FAIL cont_count[%0d] actual=%0d required=%0d", n, bus.count, exp_count[n]); end
            checks++; if (bus.ch_sel !== exp_sel[n]) begin failures++; $display("FAIL cont_ch_sel[%0d] actual=%0d required=%0d", n, bus.ch_sel, exp_sel[n]); end
        end
        // Already re-armed into WAIT, so one more add (ch1 = 2) must complete.
        bus.enable = 1'b0;
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) tick();
        checks++; if (bus.count !== 32'd13) begin failures++; $display("FAIL cont_tail_count actual=%0d required=13", bus.count); end
        checks++; if (bus.ch_sel !== 2'd2) begin failures++; $display("FAIL cont_tail_ch_sel actual=%0d required=2", bus.ch_sel); end
        bus.mode = 1'b0;
    endtask

    task automatic test_oneshot_sparse();
        int   bc;
        logic p;
        do_reset();
        bus.value = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.ch_mask = 4'b0101;
        bus.mode = 1'b0;
        run_oneshot(bc, p);
        checks++; if (bc != 3) begin failures++; $display("FAIL oneshot1_busy actual=%0d required=3", bc); end
        checks++; if (p !== 1'b1) begin failures++; $display("FAIL oneshot1_pulse actual=%b required=1", p); end
        checks++; if (bus.count !== 32'd1) begin failures++; $display("FAIL oneshot1_count actual=%0d required=1", bus.count); end
        checks++; if (bus.ch_sel !== 2'd1) begin failures++; $display("FAIL oneshot1_ch_sel actual=%0d required=1", bus.ch_sel); end
        tick();
        checks++; if (bus.acc_pulse !== 1'b0) begin failures++; $display("FAIL oneshot1_pulse_width actual=%b required=0", bus.acc_pulse); end
        run_oneshot(bc, p);
        checks++; if (bc != 3) begin failures++; $display("FAIL oneshot2_busy actual=%0d required=3", bc); end
        checks++; if (p !== 1'b1) begin failures++; $display("FAIL oneshot2_pulse actual=%b required=1", p); end
        checks++; if (bus.count !== 32'd4) begin failures++; $display("FAIL oneshot2_count actual=%0d required=4", bus.count); end
        checks++; if (bus.ch_sel !== 2'd3) begin failures++; $display("FAIL oneshot2_ch_sel actual=%0d required=3", bus.ch_sel); end
    endtask

    task automatic test_empty_mask();
        int   bc;
        logic p;
        do_reset();
        bus.value = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.mode = 1'b0;
        bus.ch_mask = 4'b0010;
        run_oneshot(bc, p);
        checks++; if (bus.count !== 32'd2) begin failures++; $display("FAIL empty_pre_count actual=%0d required=2", bus.count); end
        bus.ch_mask = 4'b0000;
        tick();
        run_oneshot(bc, p);
        checks++; if (bc != DELAY + 1) begin failures++; $display("FAIL empty_busy actual=%0d required=%0d", bc, DELAY + 1); end
        checks++; if (p !== 1'b0) begin failures++; $display("FAIL empty_pulse actual=%b required=0", p); end
        checks++; if (bus.count !== 32'd2) begin failures++; $display("FAIL empty_count actual=%0d required=2", bus.count); end
        checks++; if (bus.ch_sel !== 2'd2) begin failures++; $display("FAIL empty_ch_sel actual=%0d required=2", bus.ch_sel); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL empty_idle actual=%b required=0", bus.busy); end
    endtask

    task automatic test_overflow();
`ifdef ACCUM_SAT_EN
        logic [31:0] exp_count [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        exp_ovf   [3] = '{1'b0, 1'b1, 1'b1};
`else
        logic [31:0] exp_count [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0};
        logic        exp_ovf   [3] = '{1'b0, 1'b0, 1'b0};
`endif
        int   bc;
        logic p;
        do_reset();
        bus.value = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFF0};
        bus.ch_mask = 4'b0001;
        bus.mode = 1'b0;
        for (int n = 0; n < 3; n++) begin
            run_oneshot(bc, p);
            checks++; if (p !== 1'b1) begin failures++; $display("FAIL ovf_pulse[%0d] actual=%b required=1", n, p); end
            checks++; if (bus.count !== exp_count[n]) begin failures++; $display("FAIL ovf_count[%0d] actual=%h required=%h", n, bus.count, exp_count[n]); end
            checks++; if (bus.ovf !== exp_ovf[n]) begin failures++; $display("FAIL ovf_flag[%0d] actual=%b required=%b", n, bus.ovf, exp_ovf[n]); end
            checks++; if (bus.led !== 8'hFF) begin failures++; $display("FAIL ovf_led[%0d] actual=%h required=ff", n, bus.led); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic seen_pulse;
        do_reset();
        bus.value = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.ch_mask = 4'b1111;
        bus.mode = 1'b0;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_started actual=%b required=1", bus.busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.ch_sel !== 2'd0) begin failures++; $display("FAIL mid_ch_sel actual=%0d required=0", bus.ch_sel); end
        seen_pulse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.acc_pulse === 1'b1) seen_pulse = 1'b1;
        end
        checks++; if (seen_pulse !== 1'b0) begin failures++; $display("FAIL mid_no_pulse actual=%b required=0", seen_pulse); end
        checks++; if (bus.count !== 32'd0) begin failures++; $display("FAIL mid_count actual=%0d required=0", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_stays_idle actual=%b required=0", bus.busy); end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.mode = 1'b0;
        bus.ch_mask = '0;
        bus.value = '0;
        test_reset();
        test_continuous();
        test_oneshot_sparse();
        test_empty_mask();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Parametrised, multi-channel successor to the single-value enable-triggered accumulator.
- A small FSM waits a programmable number of cycles after `enable`, then adds one channel's value into a running count.
- Channels are chosen round-robin under a channel mask; one-shot and continuous modes are supported.
- A configurable slice of the count drives the LED bank of the top-level design.

Parameters:
- WIDTH, 32, accumulator and per-channel value width.
- NCH, 4, number of value channels (≥1).
- DELAY, 2, cycles spent in WAIT before each add (≥1).
- LED_W, 8, LED output width.
- LED_LSB, 16, LSB of the count slice driven to led. Constraint: LED_LSB+LED_W ≤ WIDTH.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- enable  in  1  start request, sampled in IDLE (and in ACC when mode=1).
- mode  in  1  0 = one-shot, 1 = continuous while enable is held.
- ch_mask  in  NCH  per-channel participation mask.
- value  in  NCH*WIDTH  packed channel values; channel i = value[i*WIDTH +: WIDTH].
- count  out  WIDTH  running accumulator.
- led  out  LED_W  count[LED_LSB+LED_W-1:LED_LSB], combinational from count.
- ch_sel  out  max(1,$clog2(NCH))  round-robin pointer: first channel examined at next ACC.
- busy  out  1  high in WAIT and ACC.
- acc_pulse  out  1  one-cycle registered pulse, high the cycle after an add is committed.
- ovf  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset (RST=0 at a clock edge):
  - state=IDLE, count=0, ch_sel=0, delay counter=0, acc_pulse=0, ovf=0.
  - busy=0 and led=0 follow from these.
  - Reset overrides everything. Reset during WAIT or ACC aborts the sequence, with no add and no pulse.
- States: IDLE, WAIT, ACC.
  - IDLE: if enable=1 → WAIT, delay counter loaded with DELAY-1. Otherwise stay in IDLE.
  - WAIT: if counter=0 → ACC, else decrement. enable is ignored here; once started, a sequence always completes.
  - ACC: perform the add (below). Then, if mode=1 and enable=1 → WAIT with counter reloaded; otherwise → IDLE. mode and enable are both sampled in ACC.
- Timing:
  - The add commits at the (DELAY+1)th edge after the edge that sampled enable in IDLE.
  - One-shot period is DELAY+2 cycles (IDLE→WAIT→ACC→IDLE).
  - Continuous period is DELAY+1 cycles.
- Channel selection in ACC:
  - Pick the first channel k, searching from ch_sel upward with wrap-around, where ch_mask[k]=1.
  - count ← count + value[k], then ch_sel ← (k+1) mod NCH, acc_pulse=1 next cycle.
  - ch_mask is sampled in ACC only.
- ch_mask=0 in ACC: count and ch_sel unchanged, acc_pulse stays 0, state transition as normal.
- Arithmetic: the WIDTH-bit add wraps modulo 2^WIDTH (default build).
- NCH=1: ch_sel is constant 0 and the mask bit gates the add.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined:
  - The add saturates. If the carry out is 1, count ← all-ones and ovf ← 1.
  - ovf is sticky and cleared only by reset.
  - acc_pulse still fires.
- Undefined:
  - The add wraps and ovf is tied to 0.

Test Plan:
- Reset: hold RST=0 for 2 cycles with enable=1 → count=0, led=0, busy=0, ch_sel=0, acc_pulse=0; after RST=1, FSM leaves IDLE on the first edge.
- Continuous round-robin: NCH=4, DELAY=2, mask=4'b1111, values {4,3,2,1} (ch3..ch0), mode=1, enable held → acc_pulse every 3 cycles; count 1,3,6,10,11; ch_sel 1,2,3,0,1.
- One-shot with sparse mask: mask=4'b0101, mode=0, two single-cycle enable pulses → count 1 then 4 (ch0 then ch2); each sequence takes 4 cycles with busy high for 3; ch_sel ends at 3.
- Empty mask: mask=0, enable pulse → busy high for DELAY+1 cycles; count unchanged; no acc_pulse; FSM returns to IDLE.
- Overflow: ch0=32'hFFFF_FFF0, mask=1, two adds → without macro count=32'hFFFF_FFE0, ovf=0; with ACCUM_SAT_EN count=32'hFFFF_FFFF, ovf=1 and ovf stays 1 through further adds.
- Reset mid-sequence: RST=0 for one edge while in WAIT → no add; count=0, state=IDLE, ch_sel=0, acc_pulse never asserted.
